// File: rtl/osd_video_driver.sv
// osd_video_driver
//   Generates the fetch raster for the OSD renderer, aligns the renderer and
//   camera pixels with the sync/enable flags, and mixes them into the final
//   RGB stream with DE/HS/VS. The OSD band is shown for SHOW_FRAMES whole
//   frames after every turbo_speed change. Frame-boundary updates keep the
//   OSD from tearing.
//   Optional feature: define OSD_DIM_EN to fill the OSD band background with
//   half-intensity camera video instead of solid black.
module osd_video_driver #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 144,
  parameter int H_TOTAL     = 200,
  parameter int V_TOTAL     = 160,
  parameter int H_HS        = 3,
  parameter int UI_LATENCY  = 1,
  parameter int SHOW_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  turbo_speed,
  input  logic [23:0] game_rgb,
  input  logic        ui_active,
  input  logic [23:0] ui_vid,
  output logic [9:0]  video_fetch_x,
  output logic [9:0]  video_fetch_y,
  output logic        osd_visible,
  output logic [23:0] vid_rgb,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs
);

  localparam int FL_W = $clog2(SHOW_FRAMES + 1);

  typedef enum logic {
    ST_HIDDEN = 1'b0,
    ST_SHOW   = 1'b1
  } state_t;

  // Per-pixel control flags carried alongside the renderer latency.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ui_active;
    logic vis;
  } flags_t;

  logic [9:0]      r_h_cnt;
  logic [9:0]      r_v_cnt;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [FL_W-1:0] r_frames_left;
  logic [FL_W-1:0] w_frames_left_nxt;
  logic [2:0]      r_last_speed;
  logic [2:0]      w_last_speed_nxt;
  logic            r_primed;
  logic            w_primed_nxt;
  logic            w_frame_start;
  flags_t          w_flags0;
  flags_t          r_pipe [UI_LATENCY];
  flags_t          w_flags_d;
  logic [23:0]     w_bg_rgb;
  logic [23:0]     w_mix_rgb;

  assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign video_fetch_x = r_h_cnt;
  assign video_fetch_y = r_v_cnt;
  assign osd_visible   = (r_state == ST_SHOW);

  // Raster counters: h wraps each line, v advances on the h wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == 10'(H_TOTAL - 1)) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // OSD state register; only the next-state logic decides when it moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_HIDDEN;
      r_frames_left <= '0;
      r_last_speed  <= '0;
      r_primed      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frames_left <= w_frames_left_nxt;
      r_last_speed  <= w_last_speed_nxt;
      r_primed      <= w_primed_nxt;
    end
  end

  // OSD next-state: evaluated only at frame start so visibility is frame-stable.
  always_comb begin
    // NOTE: every output of this block gets a hold value first; a path that
    // left one unassigned would infer a latch.
    w_state_nxt       = r_state;
    w_frames_left_nxt = r_frames_left;
    w_last_speed_nxt  = r_last_speed;
    w_primed_nxt      = r_primed;
    if (w_frame_start) begin
      if (!r_primed) begin
        // First frame after reset only learns the speed; never pops the OSD.
        w_last_speed_nxt = turbo_speed;
        w_primed_nxt     = 1'b1;
      end else if (turbo_speed != r_last_speed) begin
        // A change (re)starts the full display window, also while showing.
        w_last_speed_nxt  = turbo_speed;
        w_frames_left_nxt = FL_W'(SHOW_FRAMES);
        w_state_nxt       = ST_SHOW;
      end else if (r_state == ST_SHOW) begin
        if (r_frames_left <= FL_W'(1)) begin
          w_state_nxt       = ST_HIDDEN;
          w_frames_left_nxt = '0;
        end else begin
          w_frames_left_nxt = r_frames_left - FL_W'(1);
        end
      end
    end
  end

  // Stage-0 flags. On the frame-start pixel the visibility that the frame will
  // carry is the one being decided now, so take it from the next state; this
  // makes the visible window cover whole frames including pixel (0,0).
  always_comb begin
    w_flags0.de        = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    w_flags0.hs        = (r_h_cnt == 10'(H_HS));
    w_flags0.vs        = w_frame_start;
    w_flags0.ui_active = ui_active;
    w_flags0.vis       = w_frame_start ? (w_state_nxt == ST_SHOW)
                                       : (r_state == ST_SHOW);
  end

  // Delay line matching the renderer/camera latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this delay line is only a few flag bits deep and feeds the
      // outputs directly, so it is reset so that outputs are 0 out of reset.
      for (int i = 0; i < UI_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_flags0;
      for (int i = 1; i < UI_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_flags_d = r_pipe[UI_LATENCY-1];

`ifdef OSD_DIM_EN
  // Half-intensity camera video behind transparent OSD pixels.
  assign w_bg_rgb = {1'b0, game_rgb[23:17], 1'b0, game_rgb[15:9], 1'b0, game_rgb[7:1]};
`else
  // Solid black band behind transparent OSD pixels.
  assign w_bg_rgb = 24'h000000;
`endif

  // Pixel mix: blanking, opaque OSD, transparent OSD background, or camera.
  always_comb begin
    w_mix_rgb = game_rgb;
    if (!w_flags_d.de) begin
      w_mix_rgb = 24'h000000;
    end else if (w_flags_d.vis && w_flags_d.ui_active) begin
      w_mix_rgb = (ui_vid != 24'h000000) ? ui_vid : w_bg_rgb;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_rgb <= '0;
      vid_de  <= 1'b0;
      vid_hs  <= 1'b0;
      vid_vs  <= 1'b0;
    end else begin
      vid_rgb <= w_mix_rgb;
      vid_de  <= w_flags_d.de;
      vid_hs  <= w_flags_d.hs;
      vid_vs  <= w_flags_d.vs;
    end
  end

endmodule

// File: tb/tb_osd_video_driver.sv
// tb_osd_video_driver
//   Runs a scaled-down raster (12x8 clocks per frame, 5-frame OSD window) so
//   that many whole OSD windows fit in a short run. A frame-level reference
//   model predicts every output on every cycle; directed checks cover reset,
//   the show window, reload, short glitches, the mix values and mid-frame reset.
module tb_osd_video_driver;

  localparam int HA    = 8;
  localparam int VA    = 6;
  localparam int HT    = 12;
  localparam int VT    = 8;
  localparam int HSP   = 3;
  localparam int LAT   = 1;
  localparam int SF    = 5;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  turbo_speed;
  logic [23:0] game_rgb;
  logic        ui_active;
  logic [23:0] ui_vid;
  logic [9:0]  video_fetch_x;
  logic [9:0]  video_fetch_y;
  logic        osd_visible;
  logic [23:0] vid_rgb;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;

  always #5 clk = ~clk;

  osd_video_driver #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_HS(HSP), .UI_LATENCY(LAT), .SHOW_FRAMES(SF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .turbo_speed(turbo_speed),
    .game_rgb(game_rgb), .ui_active(ui_active), .ui_vid(ui_vid),
    .video_fetch_x(video_fetch_x), .video_fetch_y(video_fetch_y),
    .osd_visible(osd_visible), .vid_rgb(vid_rgb), .vid_de(vid_de),
    .vid_hs(vid_hs), .vid_vs(vid_vs)
  );

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic uia;
    logic vis;
  } tb_flags_t;

  int          checks = 0;
  int          errors = 0;
  tb_flags_t   fq[$];
  logic [23:0] exp_rgb;
  logic        exp_de, exp_hs, exp_vs;
  longint      m_t;
  bit          m_show, m_primed;
  int          m_left;
  logic [2:0]  m_last;
  int          vis_cycles, de_cycles;
  int          mode;
  longint      first_vs, prev_vs;
  bit          dir_pending;
  logic [23:0] dir_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_mix(tb_flags_t f, logic [23:0] uv, logic [23:0] gr);
    if (!f.de) return 24'h0;
    if (f.vis && f.uia) begin
      if (uv != 24'h0) return uv;
`ifdef OSD_DIM_EN
      return (gr >> 1) & 24'h7F7F7F;
`else
      return 24'h0;
`endif
    end
    return gr;
  endfunction

  function automatic logic [23:0] mix_const();
`ifdef OSD_DIM_EN
    return 24'h406020;
`else
    return 24'h000000;
`endif
  endfunction

  task automatic model_reset();
    m_t = 0; m_show = 0; m_primed = 0; m_left = 0; m_last = 3'd0;
    fq.delete();
    for (int i = 0; i < LAT; i++) fq.push_back('0);
    exp_rgb = '0; exp_de = 0; exp_hs = 0; exp_vs = 0;
    first_vs = -1; prev_vs = -1; dir_pending = 0;
  endtask

  function automatic int cur_h(); return int'(m_t % HT); endfunction
  function automatic int cur_v(); return int'((m_t / HT) % VT); endfunction

  // One pixel clock: check outputs, drive inputs, advance model, wait edge.
  task automatic step();
    int h, v;
    tb_flags_t f, fo;
    logic [23:0] uv, gr;
    h = cur_h();
    v = cur_v();
    check("cycle", {video_fetch_x, video_fetch_y, osd_visible, vid_de, vid_hs, vid_vs, vid_rgb},
          {10'(h), 10'(v), m_show, exp_de, exp_hs, exp_vs, exp_rgb});
    if (dir_pending) check("mix_directed", 64'(vid_rgb), 64'(dir_exp));
    dir_pending = 0;
    if (osd_visible) vis_cycles++;
    if (vid_de) de_cycles++;
    if (vid_vs) begin
      if (first_vs < 0) first_vs = m_t;
      else check("vs_period", 64'(m_t - prev_vs), 64'(FRAME));
      prev_vs = m_t;
    end
    // Renderer/camera stimulus
    if (mode == 1) begin
      uv = 24'hFFFFFF; gr = 24'h80C040; ui_active = 1'b1;
    end else if (mode == 2) begin
      uv = 24'h000000; gr = 24'h80C040; ui_active = 1'b1;
    end else begin
      case ($urandom_range(0, 3))
        0:       uv = 24'h000000;
        1:       uv = 24'hFFFFFF;
        default: uv = 24'($urandom);
      endcase
      gr = 24'($urandom);
      ui_active = (v >= 1 && v <= 3);
    end
    ui_vid = uv;
    game_rgb = gr;
    // Frame-level OSD rules
    if (h == 0 && v == 0) begin
      if (!m_primed) begin
        m_primed = 1; m_last = turbo_speed;
      end else if (turbo_speed != m_last) begin
        m_last = turbo_speed; m_show = 1; m_left = SF;
      end else if (m_show) begin
        m_left--;
        if (m_left == 0) m_show = 0;
      end
    end
    f.de  = (h < HA) && (v < VA);
    f.hs  = (h == HSP);
    f.vs  = (h == 0) && (v == 0);
    f.uia = ui_active;
    f.vis = m_show;
    fq.push_back(f);
    fo = fq.pop_front();
    exp_de  = fo.de;
    exp_hs  = fo.hs;
    exp_vs  = fo.vs;
    exp_rgb = exp_mix(fo, uv, gr);
    if (mode != 0 && fo.de && fo.vis && fo.uia) begin
      dir_pending = 1;
      dir_exp = (mode == 1) ? 24'hFFFFFF : mix_const();
    end
    m_t++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_line(input int line);
    int n;
    n = 0;
    while (!(cur_h() == 0 && cur_v() == line) && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (n >= 2 * FRAME) begin
      errors++;
      $error("FAIL run_to_line: line %0d not reached within %0d cycles", line, 2 * FRAME);
    end
  endtask

  initial begin
    reset_n = 1'b0; turbo_speed = 3'd3; game_rgb = '0; ui_vid = '0; ui_active = 1'b0;
    mode = 0; vis_cycles = 0; de_cycles = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {video_fetch_x, video_fetch_y, osd_visible, vid_de, vid_hs, vid_vs, vid_rgb}, 64'h0);
    reset_n = 1'b1;
    model_reset();

    // Speed held through reset never pops the OSD
    vis_cycles = 0;
    run(5 * FRAME);
    check("no_pop_at_reset", 64'(vis_cycles), 64'h0);
    check("first_vs_latency", 64'(first_vs), 64'(LAT + 1));

    de_cycles = 0;
    run(FRAME);
    check("de_per_frame", 64'(de_cycles), 64'(HA * VA));

    // Plain window: change mid-frame, visible exactly SF frames
    run_to_line(3);
    turbo_speed = 3'd0;
    vis_cycles = 0;
    run((SF + 2) * FRAME);
    check("show_window", 64'(vis_cycles), 64'(SF * FRAME));

    // Reload: 0->2 mid-frame, then 2->4 during SHOW frame 3
    run_to_line(3);
    turbo_speed = 3'd2;
    vis_cycles = 0;
    run_to_line(0);
    run(2 * FRAME);
    run_to_line(3);
    turbo_speed = 3'd4;
    run((SF + 2) * FRAME);
    check("show_reload", 64'(vis_cycles), 64'((3 + SF) * FRAME));

    // Change that reverts within one frame is ignored
    run_to_line(2);
    turbo_speed = 3'd1;
    run_to_line(5);
    turbo_speed = 3'd4;
    vis_cycles = 0;
    run(3 * FRAME);
    check("glitch_ignored", 64'(vis_cycles), 64'h0);

    // Directed mix values inside a visible OSD band
    run_to_line(3);
    turbo_speed = 3'd7;
    run_to_line(0);
    mode = 1;
    run(FRAME);
    mode = 2;
    run(FRAME);
    mode = 0;

    // Reset mid-SHOW
    run_to_line(2);
    run(5);
    check("vis_before_reset", 64'(osd_visible), 64'h1);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {video_fetch_x, video_fetch_y, osd_visible, vid_de, vid_hs, vid_vs, vid_rgb}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    vis_cycles = 0;
    run(3 * FRAME);
    check("hidden_after_reset", 64'(vis_cycles), 64'h0);
    check("first_vs_after_reset", 64'(first_vs), 64'(LAT + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
